// File: rtl/memory_reader.sv
// Block-read DMA from a registered-address single-port RAM onto a valid/ready byte stream.
// Define MEMORY_READER_CHECKSUM_EN to enable the running byte sum on CHECKSUM.
module memory_reader #(
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  START,
    input  logic [ADDR_WIDTH-1:0] BASE_ADDR,
    input  logic [ADDR_WIDTH:0]   LENGTH,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  MEM_EN,
    output logic [ADDR_WIDTH-1:0] MEM_ADDRESS,
    output logic                  MEM_WE,
    output logic [DATA_WIDTH-1:0] MEM_DI,
    input  logic [DATA_WIDTH-1:0] MEM_DO,
    output logic [DATA_WIDTH-1:0] OUT_DATA,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic [DATA_WIDTH-1:0] CHECKSUM
);
    typedef enum logic [1:0] {IDLE, READ, FLUSH} state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = 1;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH:0]   issue_q, issue_d;
    logic [ADDR_WIDTH:0]   deliver_q, deliver_d;
    logic                  inflight_q;
    logic [DATA_WIDTH-1:0] buf_q [2];
    logic [1:0]            count_q, count_d;
    logic                  rd_ptr_q;
    logic                  wr_idx;
    logic                  done_q, done_d;
    logic                  start_ok, issue, accept;

    assign MEM_WE = 1'b0;
    assign MEM_DI = '0;

    // State register
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (START) state_d = (LENGTH == '0) ? FLUSH : READ;
            end
            READ: begin
                if (issue && (issue_q == CNT_ONE)) state_d = FLUSH;
            end
            FLUSH: begin
                if (deliver_d == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        BUSY        = (state_q != IDLE);
        DONE        = done_q;
        MEM_EN      = issue;
        MEM_ADDRESS = addr_q;
    end

    // Stream side and issue gating; count_d is the occupancy left after this cycle's
    // capture and acceptance, so a byte leaving the buffer frees a slot immediately.
    always_comb begin
        start_ok  = (state_q == IDLE) && START;
        OUT_VALID = (count_q != 2'd0);
        OUT_DATA  = buf_q[rd_ptr_q];
        accept    = OUT_VALID && OUT_READY;
        count_d   = count_q + 2'(inflight_q) - 2'(accept);
        issue     = (state_q == READ) && (issue_q != '0) && (count_d < 2'd2);
        wr_idx    = rd_ptr_q ^ count_q[0];
    end

    always_comb begin
        addr_d    = addr_q;
        issue_d   = issue_q;
        deliver_d = deliver_q;
        if (start_ok) begin
            addr_d    = BASE_ADDR;
            issue_d   = LENGTH;
            deliver_d = LENGTH;
        end else begin
            if (issue) begin
                addr_d  = addr_q + ADDR_ONE;
                issue_d = issue_q - CNT_ONE;
            end
            if (accept) deliver_d = deliver_q - CNT_ONE;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            addr_q     <= '0;
            issue_q    <= '0;
            deliver_q  <= '0;
            inflight_q <= 1'b0;
            count_q    <= '0;
            rd_ptr_q   <= 1'b0;
            done_q     <= 1'b0;
            buf_q[0]   <= '0;
            buf_q[1]   <= '0;
        end else begin
            addr_q     <= addr_d;
            issue_q    <= issue_d;
            deliver_q  <= deliver_d;
            inflight_q <= issue;
            count_q    <= count_d;
            done_q     <= done_d;
            if (accept) rd_ptr_q <= ~rd_ptr_q;
            // RAM output follows the address registered on the issue edge
            if (inflight_q) buf_q[wr_idx] <= MEM_DO;
        end
    end

`ifdef MEMORY_READER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] sum_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sum_q <= '0;
        end else if (start_ok) begin
            sum_q <= '0;
        end else if (accept) begin
            sum_q <= sum_q + OUT_DATA;
        end
    end

    assign CHECKSUM = sum_q;
`else
    assign CHECKSUM = '0;
`endif

endmodule
